arrow_track_scheduler: RTL
==========================

Name: arrow_track_scheduler

Overview:
Sequences the two-player arrow playfield that the VGA pixel pipeline renders. Once per frame it judges player button presses against the hit slot and scrolls both 26-slot arrow arrays. It fetches new arrows from a chart ROM over a req/ack handshake and drives the good/bad indicators and scores. All playfield updates are committed at the vertical-sync edge so the renderer never sees a frame change mid-scan.

Parameters:
FRAMES_PER_STEP, 8, frame ticks between scroll steps (>=2)
HOLD_FRAMES, 20, frame ticks an indicator stays lit after a judgement
CHART_AW, 10, chart ROM address width

Ports:
iVGA_CLK  in  1  pixel clock, sole clock
iRST_n  in  1  reset; asynchronous, active-low
start  in  1  one-cycle pulse, begins a song from chart address 0
iVS  in  1  raw vertical sync from the sync generator, active-low
p1_buttons  in  4  player 1 buttons, asynchronous; bit0 left, bit1 down, bit2 up, bit3 right
p2_buttons  in  4  player 2 buttons, same mapping
chart_req  out  1  chart fetch request
chart_addr  out  CHART_AW  chart fetch address
chart_ack  in  1  one-cycle fetch acknowledge, chart_data valid this cycle
chart_data  in  3  arrow code
player1_indexes  out  78  player 1 slots; slot k = bits [3k+2:3k]; slot 0 = hit slot
player2_indexes  out  78  player 2 slots
player1_good_bad  out  2  00 none, 01 good, 10 bad
player2_good_bad  out  2  same encoding
p1_score  out  16  player 1 good count, saturating
p2_score  out  16  player 2 good count
playing  out  1  song in progress
song_done  out  1  song finished; held until next start

Behaviour:
- Reset: all outputs 0. Arrays 0, indicators 00, scores 0, chart_req 0, chart_addr 0, playing 0, song_done 0. All internal counters, flags and the FSM clear. Reset mid-song aborts immediately; no handshake completion is required.
- Arrow codes: 000 empty, 001 left, 010 down, 011 up, 100 right, 111 end-of-song sentinel. Codes 101 and 110 are stored as 000.
- Buttons: 2-flop synchronizer, then rising-edge detect. Edges OR into a per-player 4-bit pending mask, which clears on each frame tick.
- Frame tick: one-cycle pulse when registered iVS = 1 and current iVS = 0.
- FSM states:
  - IDLE: on start → FETCH0. Clears scores, arrays, indicators, song_done, frame counter, end flag and drain counter. chart_addr = 0. start in any other state is ignored.
  - FETCH0: chart_req = 1 until chart_ack. Latch chart_data into the prefetch register and set prefetch-valid. chart_req drops the cycle after ack. chart_addr increments on ack. → PLAY with playing = 1.
  - PLAY: on each frame tick, judge, then advance frame_cnt. On the tick where frame_cnt = FRAMES_PER_STEP-1, frame_cnt wraps to 0 and a step occurs.
  - Step: slot k ← slot k+1 for k = 0..24, slot 25 ← the prefetch code. The prefetch code is 000 if prefetch is invalid (no stall; chart_addr not advanced) or if the end flag is set. After the step, prefetch-valid clears and a new fetch starts on the next cycle, unless the end flag is set.
  - End: the end flag sets when sentinel 111 is accepted as a prefetch; 111 is never written into a slot. chart_addr = 2^CHART_AW-1 on ack also sets the end flag. After the end flag sets, 26 further steps occur, then → IDLE with playing = 0 and song_done = 1.
- Judging (per player, independent, on every frame tick, before any step that same tick):
  - pending ≠ 0 and slot0 ≠ 000 and pending = one-hot of slot0 (001→0001, 010→0010, 011→0100, 100→1000): good. Slot0 of that player's array becomes 000 in the same cycle. Score +1, saturating at 16'hFFFF.
  - pending ≠ 0 otherwise (wrong button, multiple buttons, empty slot): bad.
  - pending = 0, step this tick, slot0 ≠ 000: bad (miss).
  - A new judgement overrides the indicator and reloads the hold counter to HOLD_FRAMES. The counter decrements per tick; the indicator → 00 when it reaches 0.
- Array, indicator and score updates are registered and appear exactly 1 cycle after the frame-tick cycle. They never change at any other time.
- Latency: button edge → judgement at the next frame tick + 1 cycle.

Test Plan:
- Reset with iRST_n low mid-PLAY, chart_req high → all outputs 0 asynchronously. After release, chart_req stays 0 until start.
- start; chart returns 001,010,011,100,111 with 2-cycle ack latency → FETCH0 completes, addr = 1. After 26 steps, slot0 = 001. FRAMES_PER_STEP = 8 gives 208 ticks. song_done rises exactly 30 steps after the first step.
- slot0 = 011 and P1 presses up before the tick → player1_good_bad = 01 one cycle after tick, p1_score = 1, P1 slot0 = 000. P2 array unchanged.
- slot0 = 010, P2 presses left+down → 10. With no press at the step → 10 for a miss. Indicator returns to 00 after 20 ticks.
- chart_ack withheld across a step → slot25 = 000, chart_addr unchanged, chart_req still high. Ack then arrives and the next step loads the data.
- p1_score preset to 16'hFFFF via a force, then a good hit → score stays 16'hFFFF, indicator 01.

Source files
------------

// File: rtl/arrow_track_scheduler_if.sv
// Chart ROM fetch channel between the arrow scheduler and the chart store.
//   chart_req  : fetch request, held until chart_ack
//   chart_addr : fetch address
//   chart_ack  : one-cycle acknowledge, chart_data valid in the same cycle
//   chart_data : 3-bit arrow code
// master = scheduler side, slave = chart ROM side.
interface arrow_track_scheduler_if #(
  parameter int unsigned CHART_AW = 10
) ();
  logic                chart_req;
  logic [CHART_AW-1:0] chart_addr;
  logic                chart_ack;
  logic [2:0]          chart_data;

  modport master (
    output chart_req,
    output chart_addr,
    input  chart_ack,
    input  chart_data
  );

  modport slave (
    input  chart_req,
    input  chart_addr,
    output chart_ack,
    output chart_data
  );
endinterface

// File: rtl/arrow_track_scheduler.sv
// Two-player arrow playfield sequencer. Once per frame (falling edge of iVS) it judges
// button presses against the hit slot (slot 0), scrolls both 26-slot arrays every
// FRAMES_PER_STEP frames, and refills slot 25 from a chart ROM prefetch.
//   iVGA_CLK, iRST_n          : clock, async active-low reset
//   start                     : begin a song from chart address 0 (honoured in idle only)
//   iVS                       : raw vertical sync, active-low
//   p1_buttons, p2_buttons    : asynchronous buttons {right, up, down, left}
//   chart                     : chart ROM req/ack fetch channel (master side)
//   player1/2_indexes         : 26 x 3-bit slots, slot 0 in bits [2:0]
//   player1/2_good_bad        : 00 none, 01 good, 10 bad
//   p1_score, p2_score        : saturating good counts
//   playing, song_done        : song status
module arrow_track_scheduler #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned HOLD_FRAMES     = 20,
  parameter int unsigned CHART_AW        = 10
) (
  input  logic                          iVGA_CLK,
  input  logic                          iRST_n,
  input  logic                          start,
  input  logic                          iVS,
  input  logic [3:0]                    p1_buttons,
  input  logic [3:0]                    p2_buttons,
  arrow_track_scheduler_if.master       chart,
  output logic [77:0]                   player1_indexes,
  output logic [77:0]                   player2_indexes,
  output logic [1:0]                    player1_good_bad,
  output logic [1:0]                    player2_good_bad,
  output logic [15:0]                   p1_score,
  output logic [15:0]                   p2_score,
  output logic                          playing,
  output logic                          song_done
);
  localparam int unsigned FrameW = $clog2(FRAMES_PER_STEP);
  localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StFetch0, StPlay} state_e;

  state_e                    state_q, state_d;
  logic                      vs_q;
  logic [1:0][3:0]           btn_meta_q, btn_sync_q, btn_prev_q, btn_edge;
  logic [1:0][3:0]           pend_q, pend_d;
  logic [1:0][77:0]          slots_q, slots_d;
  logic [1:0][1:0]           gb_q, gb_d;
  logic [1:0][HoldW-1:0]     hold_q, hold_d;
  logic [15:0]               p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic                      req_q, req_d;
  logic [CHART_AW-1:0]       addr_q, addr_d;
  logic [2:0]                pf_code_q, pf_code_d;
  logic                      pf_valid_q, pf_valid_d;
  logic                      end_q, end_d;
  logic [4:0]                drain_q, drain_d;
  logic [FrameW-1:0]         frame_q, frame_d;
  logic                      playing_q, playing_d, done_q, done_d;
  logic                      tick, step;
  logic [1:0]                good;
  logic [2:0]                new_code;

  function automatic logic [3:0] code_onehot(logic [2:0] code);
    unique case (code)
      3'b001:  return 4'b0001;
      3'b010:  return 4'b0010;
      3'b011:  return 4'b0100;
      3'b100:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  assign tick     = vs_q & ~iVS;
  assign btn_edge = btn_sync_q & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    slots_d    = slots_q;
    gb_d       = gb_q;
    hold_d     = hold_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pf_code_d  = pf_code_q;
    pf_valid_d = pf_valid_q;
    end_d      = end_q;
    drain_d    = drain_q;
    frame_d    = frame_q;
    playing_d  = playing_q;
    done_d     = done_q;
    good       = 2'b00;
    step       = 1'b0;
    new_code   = 3'b000;

    for (int p = 0; p < 2; p++) begin
      pend_d[p] = (tick ? 4'b0000 : pend_q[p]) | btn_edge[p];
      if (tick && hold_q[p] != '0) begin
        hold_d[p] = hold_q[p] - HoldW'(1);
        if (hold_q[p] == HoldW'(1)) gb_d[p] = 2'b00;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch0;
          p1_score_d = '0;
          p2_score_d = '0;
          slots_d    = '0;
          gb_d       = '0;
          hold_d     = '0;
          done_d     = 1'b0;
          frame_d    = '0;
          end_d      = 1'b0;
          drain_d    = '0;
          pf_valid_d = 1'b0;
          addr_d     = '0;
          req_d      = 1'b1;
        end
      end
      StFetch0: begin
        if (chart.chart_ack) begin
          state_d   = StPlay;
          playing_d = 1'b1;
        end
      end
      StPlay: begin
        if (tick) begin
          step    = (frame_q == FrameW'(FRAMES_PER_STEP - 1));
          frame_d = step ? '0 : frame_q + FrameW'(1);
          // Judge against the pre-step slot 0; a good hit's clear is shifted out by a step.
          for (int p = 0; p < 2; p++) begin
            if (pend_q[p] != 4'b0000) begin
              hold_d[p] = HoldW'(HOLD_FRAMES);
              if (slots_q[p][2:0] != 3'b000 && pend_q[p] == code_onehot(slots_q[p][2:0])) begin
                good[p]         = 1'b1;
                gb_d[p]         = 2'b01;
                slots_d[p][2:0] = 3'b000;
              end else begin
                gb_d[p] = 2'b10;
              end
            end else if (step && slots_q[p][2:0] != 3'b000) begin
              hold_d[p] = HoldW'(HOLD_FRAMES);
              gb_d[p]   = 2'b10;
            end
          end
          if (step) begin
            // Sentinel and missing prefetch both feed an empty slot.
            if (pf_valid_q && !end_q && pf_code_q != 3'b111) new_code = pf_code_q;
            for (int p = 0; p < 2; p++) slots_d[p] = {new_code, slots_q[p][77:3]};
            pf_valid_d = 1'b0;
            if (end_q) begin
              if (drain_q == 5'd25) begin
                state_d   = StIdle;
                playing_d = 1'b0;
                done_d    = 1'b1;
              end else begin
                drain_d = drain_q + 5'd1;
              end
            end else if (pf_valid_q && pf_code_q == 3'b111) begin
              end_d = 1'b1;
            end else if (pf_valid_q) begin
              req_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ack is taken after the step logic so data arriving on a step cycle is kept.
    if (state_q != StIdle && req_q && chart.chart_ack) begin
      pf_code_d  = (chart.chart_data == 3'b101 || chart.chart_data == 3'b110) ? 3'b000
                                                                               : chart.chart_data;
      pf_valid_d = 1'b1;
      req_d      = 1'b0;
      addr_d     = addr_q + CHART_AW'(1);
      if (addr_q == '1) end_d = 1'b1;
    end

    if (good[0] && p1_score_q != 16'hFFFF) p1_score_d = p1_score_q + 16'd1;
    if (good[1] && p2_score_q != 16'hFFFF) p2_score_d = p2_score_q + 16'd1;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= StIdle;
      vs_q       <= 1'b0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      pend_q     <= '0;
      slots_q    <= '0;
      gb_q       <= '0;
      hold_q     <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      pf_code_q  <= '0;
      pf_valid_q <= 1'b0;
      end_q      <= 1'b0;
      drain_q    <= '0;
      frame_q    <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= iVS;
      btn_meta_q <= {p2_buttons, p1_buttons};
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      pend_q     <= pend_d;
      slots_q    <= slots_d;
      gb_q       <= gb_d;
      hold_q     <= hold_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pf_code_q  <= pf_code_d;
      pf_valid_q <= pf_valid_d;
      end_q      <= end_d;
      drain_q    <= drain_d;
      frame_q    <= frame_d;
      playing_q  <= playing_d;
      done_q     <= done_d;
    end
  end

  assign chart.chart_req  = req_q;
  assign chart.chart_addr = addr_q;
  assign player1_indexes  = slots_q[0];
  assign player2_indexes  = slots_q[1];
  assign player1_good_bad = gb_q[0];
  assign player2_good_bad = gb_q[1];
  assign p1_score         = p1_score_q;
  assign p2_score         = p2_score_q;
  assign playing          = playing_q;
  assign song_done        = done_q;
endmodule
